hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage pipeline around the execute stage.
- Generates forwarding selects for the A/B forward muxes in execute.
- Generates stall/flush controls for the F, D, E and M pipeline registers, covering load-use hazards, taken branches/jumps and a multi-cycle MDU operation held in E.
- Keeps a saturating stall-cycle counter for performance observation.

Parameters:
MDU_LATENCY, 4, cycles a multi-cycle op occupies E (>=1)
CNT_WIDTH, 16, width of stall_cycles counter

Ports:
clk  input  1  pipeline clock, rising edge
rst_n  input  1  asynchronous active-low reset
rs1_d  input  5  rs1 of instruction in D
rs2_d  input  5  rs2 of instruction in D
rs1_e  input  5  rs1 of instruction in E
rs2_e  input  5  rs2 of instruction in E
rd_e  input  5  rd of instruction in E
res_src_e  input  2  result source in E; 2'b01 = load
pc_src_e  input  1  branch taken or jump in E
mdu_start_e  input  1  instruction in E is a multi-cycle MDU op
rd_m  input  5  rd in M
reg_write_m  input  1  M writes register file
rd_w  input  5  rd in W
reg_write_w  input  1  W writes register file
forward_a_e  output  2  A forward select: 00 rd1_e, 01 result_w, 10 alu_result_m
forward_b_e  output  2  B forward select, same encoding
stall_f  output  1  hold PC
stall_d  output  1  hold F/D register
stall_e  output  1  hold D/E register
flush_d  output  1  clear F/D register
flush_e  output  1  clear D/E register
flush_m  output  1  clear E/M register (bubble)
mdu_done  output  1  MDU result valid in E this cycle
stall_cycles  output  CNT_WIDTH  saturating count of cycles with stall_f=1

Behaviour:
Forwarding (combinational):
- forward_a_e = 10 if reg_write_m && rd_m!=0 && rd_m==rs1_e.
- Otherwise 01 if reg_write_w && rd_w!=0 && rd_w==rs1_e.
- Otherwise 00.
- M has priority over W. x0 never forwards.
- forward_b_e is identical, using rs2_e.
- Forwarding is not gated by reset or stall.

Load-use:
- lwstall = res_src_e==01 && rd_e!=0 && (rd_e==rs1_d || rd_e==rs2_d).
- lwstall gives stall_f=stall_d=1 and flush_e=1 (one bubble).

Branch:
- pc_src_e=1 gives flush_d=flush_e=1.
- pc_src_e overrides lwstall: stall_f and stall_d stay 0 for that cycle.

MDU FSM (states IDLE, BUSY; registered state and down-counter cnt, width clog2(MDU_LATENCY)+1):
- IDLE, mdu_start_e=1, MDU_LATENCY>1:
  - stall_f=stall_d=stall_e=1, flush_m=1.
  - Next state BUSY, cnt<=MDU_LATENCY-2.
- IDLE, mdu_start_e=1, MDU_LATENCY==1:
  - mdu_done=1, no stall, stay IDLE.
- BUSY, cnt!=0:
  - Same stall/flush_m as above, cnt<=cnt-1.
- BUSY, cnt==0:
  - No MDU stall, mdu_done=1, next state IDLE.
  - mdu_start_e is ignored in this cycle; the op is leaving E.
- Net effect: the MDU op occupies E for exactly MDU_LATENCY cycles, with MDU_LATENCY-1 stall cycles.

MDU stall interactions:
- While an MDU stall is active, lwstall-driven flush_e is suppressed, since E holds.
- pc_src_e is ignored while BUSY.
- Final stall_f = lwstall_eff || mdu_stall. stall_d is the same.
- Final stall_e = mdu_stall.

stall_cycles:
- Increments on each clk edge where stall_f=1.
- Saturates at all-ones; no wrap.

Reset:
- Reset is asynchronous and takes effect mid-operation. It forces state IDLE, cnt 0 and stall_cycles 0.
- While rst_n=0, stall_*, flush_* and mdu_done are forced to 0.
- forward_* remain combinational.
- An MDU op aborted by reset produces no mdu_done.

Test Plan:
- Forwarding: rs1_e=5, rd_m=5, reg_write_m=1, rd_w=5, reg_write_w=1 -> forward_a_e=10. Drop reg_write_m -> 01. Set rs1_e=0 with rd_m=0 -> 00.
- Load-use: res_src_e=01, rd_e=7, rs2_d=7 -> stall_f=stall_d=flush_e=1 for one cycle, stall_e=0. Change rd_e=0 -> no stall.
- Branch vs load-use: same load-use setup plus pc_src_e=1 -> flush_d=flush_e=1, stall_f=stall_d=0.
- MDU, MDU_LATENCY=4: pulse mdu_start_e at cycle T and hold it while in E -> stall_f/d/e and flush_m high in T..T+2; mdu_done=1 only at T+3; stall_cycles increases by 3.
- Reset mid-MDU: assert rst_n=0 at T+1 -> all stalls drop immediately, stall_cycles=0, no mdu_done. After release, state IDLE; a new mdu_start_e gives a full 4-cycle sequence.
- Saturation: CNT_WIDTH=4, force 20 consecutive stall cycles -> stall_cycles holds 15.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard/sequencing controller: forwarding selects, load-use/branch/MDU stall+flush, stall counter.
// Latency: forwarding and stall/flush are combinational; MDU FSM and stall counter are registered.
// Backpressure: a multi-cycle MDU op in E holds F/D/E and bubbles M until its last cycle.
module hazard_ctrl #(
  parameter int MDU_LATENCY = 4,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [4:0]           rs1_d,
  input  logic [4:0]           rs2_d,
  input  logic [4:0]           rs1_e,
  input  logic [4:0]           rs2_e,
  input  logic [4:0]           rd_e,
  input  logic [1:0]           res_src_e,
  input  logic                 pc_src_e,
  input  logic                 mdu_start_e,
  input  logic [4:0]           rd_m,
  input  logic                 reg_write_m,
  input  logic [4:0]           rd_w,
  input  logic                 reg_write_w,
  output logic [1:0]           forward_a_e,
  output logic [1:0]           forward_b_e,
  output logic                 stall_f,
  output logic                 stall_d,
  output logic                 stall_e,
  output logic                 flush_d,
  output logic                 flush_e,
  output logic                 flush_m,
  output logic                 mdu_done,
  output logic [CNT_WIDTH-1:0] stall_cycles
);

  localparam int CW = $clog2(MDU_LATENCY) + 1;
  // First BUSY count; only meaningful when the op needs more than one cycle.
  localparam logic [CW-1:0] CNT_INIT = (MDU_LATENCY > 1) ? CW'(MDU_LATENCY - 2) : '0;
  localparam bit MULTI = (MDU_LATENCY > 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]  stall_cycles_q, stall_cycles_d;
  logic                  mdu_stall, mdu_done_raw;
  logic                  lwstall, lwstall_eff, pc_src_eff;

  // Forwarding: M beats W, x0 never forwards; not gated by reset or stall.
  always_comb begin
    forward_a_e = 2'b00;
    forward_b_e = 2'b00;
    if (reg_write_m && rd_m != 5'd0 && rd_m == rs1_e)      forward_a_e = 2'b10;
    else if (reg_write_w && rd_w != 5'd0 && rd_w == rs1_e) forward_a_e = 2'b01;
    if (reg_write_m && rd_m != 5'd0 && rd_m == rs2_e)      forward_b_e = 2'b10;
    else if (reg_write_w && rd_w != 5'd0 && rd_w == rs2_e) forward_b_e = 2'b01;
  end

  // MDU state and down-counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // MDU next state: a start in IDLE enters BUSY; BUSY counts down to the final cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (mdu_start_e && MULTI) begin
        state_d = BUSY;
        cnt_d   = CNT_INIT;
      end
      BUSY: if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
            else             state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // MDU outputs: stall every cycle of the op except the last, where the result is valid.
  always_comb begin
    mdu_stall    = 1'b0;
    mdu_done_raw = 1'b0;
    case (state_q)
      IDLE: begin
        mdu_stall    = mdu_start_e && MULTI;
        mdu_done_raw = mdu_start_e && !MULTI;
      end
      BUSY: begin
        mdu_stall    = (cnt_q != '0);
        mdu_done_raw = (cnt_q == '0);
      end
      default: ;
    endcase
  end

  // Combine load-use, branch and MDU hazards; everything is quiet while in reset.
  always_comb begin
    lwstall     = (res_src_e == 2'b01) && (rd_e != 5'd0) && (rd_e == rs1_d || rd_e == rs2_d);
    // A branch resolving while an older MDU op is still busy cannot be real, so ignore it.
    pc_src_eff  = pc_src_e && (state_q != BUSY);
    lwstall_eff = lwstall && !pc_src_eff;
    stall_f     = rst_n && (lwstall_eff || mdu_stall);
    stall_d     = rst_n && (lwstall_eff || mdu_stall);
    stall_e     = rst_n && mdu_stall;
    flush_d     = rst_n && pc_src_eff;
    // E is held during an MDU stall, so the load-use bubble must not clear it.
    flush_e     = rst_n && (pc_src_eff || (lwstall_eff && !mdu_stall));
    flush_m     = rst_n && mdu_stall;
    mdu_done    = rst_n && mdu_done_raw;
  end

  // Saturating stall counter next value.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall_f && stall_cycles_q != {CNT_WIDTH{1'b1}}) stall_cycles_d = stall_cycles_q + 1'b1;
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cycles_q <= '0;
    else        stall_cycles_q <= stall_cycles_d;
  end

  assign stall_cycles = stall_cycles_q;

endmodule
